// File: rtl/fir_decim_buffer.sv
// Decimates the FIR output stream by DECIM and buffers kept samples in a small FIFO
// drained via valid/ready; define FIR_DECIM_AVG_EN to push the group mean instead.
module fir_decim_buffer #(
  parameter int DATA_W     = 16,
  parameter int DECIM      = 4,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow
);

  localparam int PH_W  = $clog2(DECIM);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [PH_W-1:0]       phase;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow_q;
  logic [DATA_W-1:0]     mem [DEPTH];

  logic                  keep;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic [DATA_W-1:0]     keep_data;

  assign keep = in_valid && (phase == PH_W'(DECIM - 1));
  assign full = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign pop  = out_valid && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push = keep && (!full || pop);

`ifdef FIR_DECIM_AVG_EN
  localparam int ACC_W = DATA_W + PH_W;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;

  function automatic logic [DATA_W-1:0] mean_trunc(input logic [ACC_W-1:0] sum);
    return DATA_W'(sum >> PH_W);
  endfunction

  assign acc_sum   = acc + ACC_W'(in_data);
  assign keep_data = mean_trunc(acc_sum);

  // Group accumulator restarts on every keep, including dropped groups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (in_valid) begin
      acc <= keep ? '0 : acc_sum;
    end
  end
`else
  assign keep_data = in_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      phase      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (in_valid) phase <= phase + PH_W'(1);
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      if (push && !pop) begin
        count <= count + (DEPTH_LOG2 + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (DEPTH_LOG2 + 1)'(1);
      end
      if (keep && !push) overflow_q <= 1'b1;
    end
  end

  // Storage is zeroed on reset so the head reads 0 afterwards; clear leaves it intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !clear) begin
      mem[wr_ptr] <= keep_data;
    end
  end

  assign out_valid  = (count != '0);
  assign out_data   = mem[rd_ptr];
  assign fifo_count = count;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Self-checking bench for fir_decim_buffer: queue-based model checked every cycle,
// plus literal expectations; FIR_DECIM_AVG_EN selects the averaging model.
module tb_fir_decim_buffer;

  localparam int DATA_W = 16;
  localparam int DECIM  = 4;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic [3:0]        fifo_count;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  // Model state: expected FIFO contents, valid-sample index, sticky drop flag, group sum.
  logic [DATA_W-1:0] mq[$];
  int                m_idx = 0;
  logic              m_ovf = 1'b0;
  longint            m_acc = 0;

  fir_decim_buffer #(.DATA_W(DATA_W), .DECIM(DECIM), .DEPTH_LOG2(3)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cmp_valid", out_valid, (mq.size() != 0));
    check("cmp_count", fifo_count, mq.size());
    check("cmp_ovf", overflow, m_ovf);
    if (mq.size() != 0) check("cmp_data", out_data, mq[0]);
  end

  task automatic model_reset();
    mq.delete();
    m_idx = 0;
    m_ovf = 1'b0;
    m_acc = 0;
  endtask

  // Drive one cycle; the model advances at the same clock edge as the DUT.
  task automatic cycle(input logic iv, input logic [DATA_W-1:0] d, input logic rdy,
                       input logic clr);
    logic [DATA_W-1:0] nq[$];
    int                n_idx;
    logic              n_ovf;
    longint            n_acc;
    logic              was_full;
    logic              do_pop;
    logic [DATA_W-1:0] kept;
    in_valid = iv; in_data = d; out_ready = rdy; clear = clr;
    nq = mq; n_idx = m_idx; n_ovf = m_ovf; n_acc = m_acc;
    if (clr) begin
      nq.delete(); n_idx = 0; n_ovf = 1'b0; n_acc = 0;
    end else begin
      was_full = (nq.size() == DEPTH);
      do_pop = (nq.size() != 0) && rdy;
      if (do_pop) void'(nq.pop_front());
      if (iv) begin
        n_idx++;
        n_acc += d;
        if (n_idx % DECIM == 0) begin
`ifdef FIR_DECIM_AVG_EN
          kept = DATA_W'(n_acc / DECIM);
`else
          kept = d;
`endif
          n_acc = 0;
          if (was_full && !do_pop) n_ovf = 1'b1;
          else nq.push_back(kept);
        end
      end
    end
    @(posedge clk);
    mq = nq; m_idx = n_idx; m_ovf = n_ovf; m_acc = n_acc;
    #1;
  endtask

  function automatic int group_val(input int last);
`ifdef FIR_DECIM_AVG_EN
    return last - 2;
`else
    return last;
`endif
  endfunction

  logic [DATA_W-1:0] got[$];
  int maxcnt;

  initial begin
    #1;
    check("reset_valid", out_valid, 0);
    check("reset_data", out_data, 0);
    check("reset_count", fifo_count, 0);
    check("reset_ovf", overflow, 0);
    #13 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: streaming with ready high
    got.delete(); maxcnt = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1, DATA_W'(i), 1, 0);
      if (out_valid) got.push_back(out_data);
      if (fifo_count > maxcnt) maxcnt = fifo_count;
    end
    cycle(0, 0, 1, 0);
    check("t1_n", got.size(), 3);
`ifdef FIR_DECIM_AVG_EN
    check("t1_v0", got[0], 1); check("t1_v1", got[1], 5); check("t1_v2", got[2], 9);
`else
    check("t1_v0", got[0], 3); check("t1_v1", got[1], 7); check("t1_v2", got[2], 11);
`endif
    check("t1_maxcnt", maxcnt, 1);
    check("t1_ovf", overflow, 0);

    // 2: fill to overflow, then drain in order
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 36; i++) cycle(1, DATA_W'(i), 0, 0);
    check("t2_count", fifo_count, 8);
    check("t2_ovf", overflow, 1);
    got.delete();
    for (int i = 0; i < 8; i++) begin
      got.push_back(out_data);
      cycle(0, 0, 1, 0);
    end
    for (int i = 0; i < 8; i++) check("t2_drain", got[i], group_val(4 * i + 3));
    check("t2_empty", out_valid, 0);
    check("t2_ovf_sticky", overflow, 1);

    // 3: push and pop together while full
    cycle(0, 0, 0, 1);
    check("t3_clr_ovf", overflow, 0);
    for (int i = 0; i < 35; i++) cycle(1, DATA_W'(i), 0, 0);
    check("t3_full", fifo_count, 8);
    cycle(1, 35, 1, 0);
    check("t3_count", fifo_count, 8);
    check("t3_ovf", overflow, 0);
    check("t3_head", out_data, group_val(7));
    got.delete();
    for (int i = 0; i < 8; i++) begin
      got.push_back(out_data);
      cycle(0, 0, 1, 0);
    end
    check("t3_tail", got[7], group_val(35));

    // 4: gaps hold the phase
    cycle(0, 0, 0, 1);
    cycle(1, 5, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0); cycle(1, 6, 0, 0);
    cycle(1, 7, 0, 0); cycle(0, 0, 0, 0); cycle(1, 8, 0, 0);
    check("t4_count", fifo_count, 1);
`ifdef FIR_DECIM_AVG_EN
    check("t4_data", out_data, 6);
`else
    check("t4_data", out_data, 8);
`endif

    // 5: clear beats a keep event, phase restarts
    for (int i = 0; i < 11; i++) cycle(1, DATA_W'(50 + i), 0, 0);
    check("t5_pre", fifo_count, 3);
    cycle(1, 99, 0, 1);
    check("t5_count", fifo_count, 0);
    check("t5_valid", out_valid, 0);
    check("t5_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) cycle(1, DATA_W'(100 + i), 0, 0);
    check("t5_phase", fifo_count, 1);
    check("t5_data", out_data, group_val(103));

`ifdef FIR_DECIM_AVG_EN
    // 6: mean with truncation and full-scale input
    cycle(0, 0, 0, 1);
    cycle(1, 10, 0, 0); cycle(1, 20, 0, 0); cycle(1, 30, 0, 0); cycle(1, 40, 0, 0);
    check("t6_mean", out_data, 25);
    cycle(0, 0, 1, 0);
    cycle(1, 1, 0, 0); cycle(1, 1, 0, 0); cycle(1, 1, 0, 0); cycle(1, 2, 0, 0);
    check("t6_trunc", out_data, 1);
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 16'hFFFF, 0, 0);
    check("t6_max", out_data, 65535);
    cycle(0, 0, 1, 0);
`endif

    // async reset mid-stream with a full, overflowed FIFO
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 40; i++) cycle(1, DATA_W'(200 + i), 0, 0);
    check("t7_pre_ovf", overflow, 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("t7_valid", out_valid, 0);
    check("t7_data", out_data, 0);
    check("t7_count", fifo_count, 0);
    check("t7_ovf", overflow, 0);
    in_valid = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) cycle(1, DATA_W'(300 + i), 1, 0);
    check("t7_after", out_data, group_val(303));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
